// File: rtl/serial_adder_controller.sv
// Bit-serial W-bit adder: latches operands on start, pushes one bit pair per clock
// through a single full_adder (LSB first) and presents {carry_out, sum} with a done pulse.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_controller #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_carry_in,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_sum,
  output logic         o_carry_out
);

  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [W-1:0]    r_a, r_b;
  logic [W-2:0]    r_res;
  logic            r_carry;
  logic [CntW-1:0] r_cnt;
  logic [W-1:0]    r_sum;
  logic            r_cout;

  logic            w_fa_s, w_fa_c;
  logic            w_accept, w_last;
  logic [W-1:0]    w_res_next;

  full_adder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  assign w_accept   = i_start && (r_state != StRun);
  assign w_last     = (r_state == StRun) && (r_cnt == CntW'(W - 1));
  // New sum bit enters at the MSB; after W shifts bit i sits at position i.
  assign w_res_next = {w_fa_s, r_res};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_next = StRun;
      StRun:   if (w_last) w_state_next = StDone;
      StDone:  w_state_next = i_start ? StRun : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_busy      = (r_state == StRun);
    o_done      = (r_state == StDone);
    o_sum       = r_sum;
    o_carry_out = r_cout;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_b;
      r_carry <= i_carry_in;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == StRun) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_fa_c;
      r_res   <= w_res_next[W-1:1];
      r_cnt   <= r_cnt + CntW'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_fa_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_controller.sv
// Bench for serial_adder_controller at W=8 and W=13: cycle-level model plus directed
// and randomized additions.

module tb_serial_adder_controller;

  logic        clk = 1'b0;
  logic        rst_n [2];
  logic        start [2];
  logic        cin   [2];
  logic [31:0] opa   [2];
  logic [31:0] opb   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [31:0] sum   [2];
  logic        cout  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int wid(input int g);
    return (g == 0) ? 8 : 13;
  endfunction

  function automatic logic [32:0] ref_add(input int g, input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    longint unsigned mask;
    mask = (64'd1 << wid(g)) - 64'd1;
    return 33'((longint'(a) & mask) + (longint'(b) & mask) + longint'(c));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 8 : 13;
    logic [W-1:0] w_sum;
    logic         l_rst_n;

    assign l_rst_n = rst_n[g];

    serial_adder_controller #(.W(W)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n[g]),
      .i_start     (start[g]),
      .i_a         (opa[g][W-1:0]),
      .i_b         (opb[g][W-1:0]),
      .i_carry_in  (cin[g]),
      .o_busy      (busy[g]),
      .o_done      (done[g]),
      .o_sum       (w_sum),
      .o_carry_out (cout[g])
    );
    assign sum[g] = 32'(w_sum);

    // Model: cycles of busy remaining, pending result, last delivered result.
    int         m_rem;
    logic       m_done;
    logic [W:0] m_res, m_pend;

    always @(posedge clk or negedge l_rst_n) begin
      if (!l_rst_n) begin
        m_rem  <= 0;
        m_done <= 1'b0;
        m_res  <= '0;
        m_pend <= '0;
      end else begin
        m_done <= (m_rem == 1);
        if (m_rem == 1) m_res <= m_pend;
        if (start[g] && m_rem == 0) begin
          m_rem  <= W;
          m_pend <= {1'b0, opa[g][W-1:0]} + {1'b0, opb[g][W-1:0]} + (W + 1)'(cin[g]);
        end else if (m_rem > 0) begin
          m_rem <= m_rem - 1;
        end
      end
    end

    always begin
      @(negedge clk);
      #1;
      check($sformatf("dut%0d busy", g), 64'(busy[g]), 64'(m_rem > 0));
      check($sformatf("dut%0d done", g), 64'(done[g]), 64'(m_done));
      check($sformatf("dut%0d sum", g), 64'(sum[g]), 64'(m_res[W-1:0]));
      check($sformatf("dut%0d carry_out", g), 64'(cout[g]), 64'(m_res[W]));
    end
  end

  // Issue one add on DUT g and return the result seen at done, the done latency in
  // cycles and the number of busy cycles; lat=-1 on timeout.
  task automatic run_add(input int g, input logic [31:0] a, input logic [31:0] b, input logic c,
                         output logic [32:0] res, output int lat, output int nbusy);
    @(negedge clk);
    opa[g]   = a;
    opb[g]   = b;
    cin[g]   = c;
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    opa[g]   = $urandom;
    opb[g]   = $urandom;
    cin[g]   = 1'($urandom);
    lat   = 1;
    nbusy = 0;
    while (lat <= 40 && !done[g]) begin
      if (busy[g]) nbusy++;
      @(negedge clk);
      lat++;
    end
    res = (33'(cout[g]) << wid(g)) | 33'(sum[g]);
    if (!done[g]) begin
      lat = -1;
      total++;
      bad++;
      $display("FAIL dut%0d done timeout: got no done, want done within 40 cycles", g);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [32:0] res, exp;
    logic [31:0] ca, cb;
    logic        cc;
    int          lat, nb, ndone, last, since;

    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0;
      start[g] = 1'b0;
      cin[g]   = 1'b0;
      opa[g]   = '0;
      opb[g]   = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", 64'(busy[0]), 64'd0);
    check("reset done", 64'(done[0]), 64'd0);
    check("reset sum", 64'(sum[0]), 64'd0);
    check("reset carry_out", 64'(cout[0]), 64'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Directed results with hand-computed values.
    run_add(0, 32'hFF, 32'h01, 1'b0, res, lat, nb);
    check("ff+01 result", 64'(res), 64'h100);
    check("ff+01 latency", 64'(lat), 64'd9);
    check("ff+01 busy cycles", 64'(nb), 64'd8);
    run_add(0, 32'hA5, 32'h5A, 1'b1, res, lat, nb);
    check("a5+5a+1 result", 64'(res), 64'h100);
    run_add(0, 32'h12, 32'h34, 1'b0, res, lat, nb);
    check("12+34 result", 64'(res), 64'h046);

    // Start pulsed at E3 of a running add must be ignored.
    @(negedge clk);
    opa[0] = 32'h0F; opb[0] = 32'h01; cin[0] = 1'b0; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    opa[0] = 32'h77; opb[0] = 32'h11; cin[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    ndone = 0;
    res   = '0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done[0]) begin
        ndone++;
        res = (33'(cout[0]) << 8) | 33'(sum[0]);
      end
    end
    check("ignored start done count", 64'(ndone), 64'd1);
    check("ignored start result", 64'(res), 64'h010);

    // Start held high: new operands during each DONE, scrambled mid-RUN.
    @(negedge clk);
    ca = $urandom; cb = $urandom; cc = 1'($urandom);
    opa[0] = ca; opb[0] = cb; cin[0] = cc; start[0] = 1'b1;
    exp   = ref_add(0, ca, cb, cc);
    since = 0;
    ndone = 0;
    last  = -1;
    for (int cyc = 1; cyc <= 60 && ndone < 4; cyc++) begin
      @(negedge clk);
      since++;
      if (since == 4) begin
        opa[0] = $urandom; opb[0] = $urandom; cin[0] = 1'($urandom);
      end
      if (done[0]) begin
        res = (33'(cout[0]) << 8) | 33'(sum[0]);
        check($sformatf("held start result %0d", ndone), 64'(res), 64'(exp));
        if (last >= 0) check($sformatf("held start interval %0d", ndone), 64'(cyc - last), 64'd9);
        last = cyc;
        ndone++;
        since = 0;
        if (ndone < 4) begin
          ca = $urandom; cb = $urandom; cc = 1'($urandom);
          opa[0] = ca; opb[0] = cb; cin[0] = cc;
          exp = ref_add(0, ca, cb, cc);
        end else begin
          start[0] = 1'b0;
        end
      end
    end
    check("held start done count", 64'(ndone), 64'd4);

    // Reset mid-RUN: immediate clear, no done afterwards, then a normal add.
    @(negedge clk);
    opa[0] = 32'h33; opb[0] = 32'h44; cin[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    check("mid-run reset busy", 64'(busy[0]), 64'd0);
    check("mid-run reset done", 64'(done[0]), 64'd0);
    check("mid-run reset sum", 64'(sum[0]), 64'd0);
    check("mid-run reset carry_out", 64'(cout[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done[0]) ndone++;
    end
    check("post-reset spurious done", 64'(ndone), 64'd0);
    run_add(0, 32'h80, 32'h80, 1'b1, res, lat, nb);
    check("post-reset result", 64'(res), 64'h101);

    // Randomized additions on both widths.
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 200; i++) begin
        ca = $urandom; cb = $urandom; cc = 1'($urandom);
        exp = ref_add(g, ca, cb, cc);
        run_add(g, ca, cb, cc, res, lat, nb);
        check($sformatf("dut%0d random add %0d", g, i), 64'(res), 64'(exp));
        if (res !== exp || lat < 0) break;
      end
    end

    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
